// File: rtl/ifu_fetch_ctrl_pkg.sv
// Shared widths, reset PC and encodings for the instruction-fetch controller.
package ifu_fetch_ctrl_pkg;

    localparam int          CPU_WIDTH  = 32;
    localparam int          INST_WIDTH = 32;
    localparam logic [31:0] RESET_PC   = 32'h8000_0000;

    typedef enum logic [1:0] {
        FETCH_IDLE = 2'd0,
        FETCH_REQ  = 2'd1,
        FETCH_WAIT = 2'd2,
        FETCH_HOLD = 2'd3
    } fetch_state_e;

    typedef enum logic [1:0] {
        PC_SEL_HOLD     = 2'd0,
        PC_SEL_SEQ      = 2'd1,
        PC_SEL_REDIRECT = 2'd2
    } pc_sel_e;

endpackage

// File: rtl/ifu_pc_next.sv
// Next-PC selection: hold, sequential +4, or word-aligned redirect target.
module ifu_pc_next #(
    parameter int CPU_WIDTH = ifu_fetch_ctrl_pkg::CPU_WIDTH
) (
    input  logic [CPU_WIDTH-1:0] pc,
    input  logic                 advance,
    input  logic                 redirect_valid,
    input  logic [CPU_WIDTH-1:0] redirect_pc,
    output logic [CPU_WIDTH-1:0] pc_next
);
    import ifu_fetch_ctrl_pkg::*;

    logic [CPU_WIDTH-1:0] pc_seq;
    logic [CPU_WIDTH-1:0] pc_target;
    pc_sel_e              sel;

    // Sequential addition wraps naturally at 2^CPU_WIDTH.
    assign pc_seq    = pc + CPU_WIDTH'(4);
    assign pc_target = redirect_pc & ~CPU_WIDTH'(3);

    // A redirect always beats a sequential advance.
    always_comb begin
        sel = PC_SEL_HOLD;
        if (redirect_valid) begin
            sel = PC_SEL_REDIRECT;
        end else if (advance) begin
            sel = PC_SEL_SEQ;
        end
    end

    always_comb begin
        unique case (sel)
            PC_SEL_SEQ:      pc_next = pc_seq;
            PC_SEL_REDIRECT: pc_next = pc_target;
            default:         pc_next = pc;
        endcase
    end

endmodule

// File: rtl/ifu_fetch_ctrl.sv
// Instruction-fetch sequencer: owns the PC, keeps a single fetch in flight and
// hands one instruction at a time to the decoder over valid/ready.
module ifu_fetch_ctrl #(
    parameter int                  CPU_WIDTH  = ifu_fetch_ctrl_pkg::CPU_WIDTH,
    parameter int                  INST_WIDTH = ifu_fetch_ctrl_pkg::INST_WIDTH,
    parameter logic [CPU_WIDTH-1:0] RESET_PC  = ifu_fetch_ctrl_pkg::RESET_PC
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  redirect_valid,
    input  logic [CPU_WIDTH-1:0]  redirect_pc,
    output logic                  imem_req_valid,
    input  logic                  imem_req_ready,
    output logic [CPU_WIDTH-1:0]  imem_req_addr,
    input  logic                  imem_resp_valid,
    input  logic [INST_WIDTH-1:0] imem_resp_data,
    output logic                  inst_valid,
    input  logic                  inst_ready,
    output logic [INST_WIDTH-1:0] inst,
    output logic [CPU_WIDTH-1:0]  inst_pc,
    output logic [CPU_WIDTH-1:0]  pc
);
    import ifu_fetch_ctrl_pkg::*;

    fetch_state_e          state, state_next;
    logic                  drop, drop_next;
    logic [INST_WIDTH-1:0] inst_next;
    logic [CPU_WIDTH-1:0]  inst_pc_next;
    logic [CPU_WIDTH-1:0]  pc_next;
    logic                  pc_advance;

    ifu_pc_next #(.CPU_WIDTH(CPU_WIDTH)) u_pc_next (
        .pc             (pc),
        .advance        (pc_advance),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .pc_next        (pc_next)
    );

    assign imem_req_addr = pc;
    assign inst_valid    = (state == FETCH_HOLD);

    // NOTE: every signal gets a default before the case so no path leaves it
    // unassigned, which would otherwise infer a latch.
    always_comb begin
        state_next     = state;
        drop_next      = drop;
        inst_next      = inst;
        inst_pc_next   = inst_pc;
        pc_advance     = 1'b0;
        imem_req_valid = 1'b0;

        unique case (state)
            FETCH_IDLE: state_next = FETCH_REQ;

            FETCH_REQ: begin
                imem_req_valid = 1'b1;
                if (imem_req_ready) begin
                    state_next = FETCH_WAIT;
                    // The accepted request carried the old pc; its reply is stale.
                    if (redirect_valid) drop_next = 1'b1;
                end
            end

            FETCH_WAIT: begin
                if (redirect_valid) begin
                    if (imem_resp_valid) begin
                        drop_next  = 1'b0;
                        state_next = FETCH_REQ;
                    end else begin
                        drop_next  = 1'b1;
                    end
                end else if (imem_resp_valid) begin
                    if (drop) begin
                        drop_next  = 1'b0;
                        state_next = FETCH_REQ;
                    end else begin
                        inst_next    = imem_resp_data;
                        inst_pc_next = pc;
                        state_next   = FETCH_HOLD;
                    end
                end
            end

            FETCH_HOLD: begin
                if (redirect_valid) begin
                    state_next = FETCH_REQ;
                end else if (inst_ready) begin
                    pc_advance = 1'b1;
                    state_next = FETCH_REQ;
                end
            end

            default: state_next = FETCH_IDLE;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values regardless of process evaluation order.
    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= FETCH_IDLE;
            pc      <= RESET_PC;
            drop    <= 1'b0;
            inst    <= '0;
            inst_pc <= '0;
        end else begin
            state   <= state_next;
            pc      <= pc_next;
            drop    <= drop_next;
            inst    <= inst_next;
            inst_pc <= inst_pc_next;
        end
    end

endmodule

// File: tb/tb_ifu_fetch_ctrl.sv
// Directed bench for ifu_fetch_ctrl with a small latency-programmable memory.
module tb_ifu_fetch_ctrl;

    logic        clk = 1'b0;
    logic        rst;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic        imem_req_valid;
    logic        imem_req_ready;
    logic [31:0] imem_req_addr;
    logic        imem_resp_valid = 1'b0;
    logic [31:0] imem_resp_data  = '0;
    logic        inst_valid;
    logic        inst_ready;
    logic [31:0] inst;
    logic [31:0] inst_pc;
    logic [31:0] pc;

    int n_vec = 0;
    int n_bad = 0;

    ifu_fetch_ctrl dut (
        .clk             (clk),
        .rst             (rst),
        .redirect_valid  (redirect_valid),
        .redirect_pc     (redirect_pc),
        .imem_req_valid  (imem_req_valid),
        .imem_req_ready  (imem_req_ready),
        .imem_req_addr   (imem_req_addr),
        .imem_resp_valid (imem_resp_valid),
        .imem_resp_data  (imem_resp_data),
        .inst_valid      (inst_valid),
        .inst_ready      (inst_ready),
        .inst            (inst),
        .inst_pc         (inst_pc),
        .pc              (pc)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] mem_data(input logic [31:0] addr);
        return addr ^ 32'h1357_9BDF;
    endfunction

    // Memory model: reply arrives in the lat-th cycle after acceptance.
    int          lat = 1;
    int          cnt = 0;
    logic        pend = 1'b0;
    logic [31:0] pend_addr = '0;
    int          hs_count = 0;
    logic [31:0] hs_addr = '0;

    always @(posedge clk) begin
        imem_resp_valid <= 1'b0;
        if (pend) begin
            if (cnt == 1) begin
                imem_resp_valid <= 1'b1;
                imem_resp_data  <= mem_data(pend_addr);
                pend            <= 1'b0;
            end else begin
                cnt <= cnt - 1;
            end
        end
        if (imem_req_valid && imem_req_ready) begin
            hs_count <= hs_count + 1;
            hs_addr  <= imem_req_addr;
            if (lat == 1) begin
                imem_resp_valid <= 1'b1;
                imem_resp_data  <= mem_data(imem_req_addr);
            end else begin
                pend      <= 1'b1;
                cnt       <= lat - 1;
                pend_addr <= imem_req_addr;
            end
        end
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(negedge clk);
    endtask

    int hs_before;

    initial begin
        rst            = 1'b1;
        redirect_valid = 1'b0;
        redirect_pc    = '0;
        imem_req_ready = 1'b1;
        inst_ready     = 1'b1;
        repeat (2) step();

        check("rst_pc",        pc,             32'h8000_0000);
        check("rst_req_valid", imem_req_valid, 32'd0);
        check("rst_inst_valid", inst_valid,    32'd0);
        check("rst_inst",      inst,           32'd0);
        check("rst_inst_pc",   inst_pc,        32'd0);
        rst = 1'b0;

        // Streaming: REQ, WAIT, HOLD per instruction.
        for (int i = 0; i < 3; i++) begin
            step();
            check("seq_req_valid", imem_req_valid, 32'd1);
            check("seq_req_addr",  imem_req_addr,  32'h8000_0000 + 32'(4 * i));
            check("seq_iv_req",    inst_valid,     32'd0);
            step();
            check("seq_wait_req",  imem_req_valid, 32'd0);
            check("seq_iv_wait",   inst_valid,     32'd0);
            step();
            check("seq_iv_hold",   inst_valid,     32'd1);
            check("seq_inst_pc",   inst_pc,        32'h8000_0000 + 32'(4 * i));
            check("seq_inst",      inst,           mem_data(32'h8000_0000 + 32'(4 * i)));
        end

        // Decoder back-pressure in HOLD.
        inst_ready = 1'b0;
        hs_before  = hs_count;
        for (int i = 0; i < 5; i++) begin
            step();
            check("bp_inst_valid", inst_valid,     32'd1);
            check("bp_inst_pc",    inst_pc,        32'h8000_0008);
            check("bp_inst",       inst,           mem_data(32'h8000_0008));
            check("bp_req_valid",  imem_req_valid, 32'd0);
            check("bp_pc",         pc,             32'h8000_0008);
        end
        inst_ready = 1'b1;
        step();
        check("bp_next_req",  imem_req_valid, 32'd1);
        check("bp_next_addr", imem_req_addr,  32'h8000_000C);
        check("bp_no_hs",     32'(hs_count),  32'(hs_before));

        // Redirect while waiting on a slow response.
        lat = 3;
        step();
        redirect_valid = 1'b1;
        redirect_pc    = 32'h8000_0103;
        step();
        redirect_valid = 1'b0;
        check("rw_pc",        pc,             32'h8000_0100);
        check("rw_req_valid", imem_req_valid, 32'd0);
        step();
        check("rw_resp_iv",   inst_valid,     32'd0);
        step();
        check("rw_drop_iv",   inst_valid,     32'd0);
        check("rw_req_valid2", imem_req_valid, 32'd1);
        check("rw_req_addr",  imem_req_addr,  32'h8000_0100);
        lat = 1;
        step();
        step();
        check("rw_iv",        inst_valid,     32'd1);
        check("rw_inst_pc",   inst_pc,        32'h8000_0100);
        check("rw_inst",      inst,           mem_data(32'h8000_0100));

        // Redirect in HOLD coinciding with inst_ready.
        redirect_valid = 1'b1;
        redirect_pc    = 32'h8000_0200;
        step();
        redirect_valid = 1'b0;
        check("rh_iv",        inst_valid,     32'd0);
        check("rh_req_valid", imem_req_valid, 32'd1);
        check("rh_req_addr",  imem_req_addr,  32'h8000_0200);

        // Request stalled four cycles with a redirect in the second.
        imem_req_ready = 1'b0;
        hs_before      = hs_count;
        step();
        check("rs_addr1", imem_req_addr, 32'h8000_0200);
        redirect_valid = 1'b1;
        redirect_pc    = 32'h8000_0040;
        step();
        redirect_valid = 1'b0;
        check("rs_valid2", imem_req_valid, 32'd1);
        check("rs_addr2",  imem_req_addr,  32'h8000_0040);
        for (int i = 0; i < 2; i++) begin
            step();
            check("rs_valid34", imem_req_valid, 32'd1);
            check("rs_addr34",  imem_req_addr,  32'h8000_0040);
        end
        check("rs_no_hs", 32'(hs_count), 32'(hs_before));
        imem_req_ready = 1'b1;
        step();
        check("rs_one_hs",  32'(hs_count), 32'(hs_before + 1));
        check("rs_hs_addr", hs_addr,       32'h8000_0040);
        step();
        check("rs_iv",      inst_valid, 32'd1);
        check("rs_inst_pc", inst_pc,    32'h8000_0040);

        // Reset while a response is in flight.
        step();
        check("rr_req_addr", imem_req_addr, 32'h8000_0044);
        lat = 2;
        step();
        rst = 1'b1;
        step();
        rst = 1'b0;
        check("rr_pc",        pc,             32'h8000_0000);
        check("rr_req_valid", imem_req_valid, 32'd0);
        check("rr_iv",        inst_valid,     32'd0);
        step();
        check("rr_iv_ignored", inst_valid,    32'd0);
        check("rr_req_valid2", imem_req_valid, 32'd1);
        check("rr_req_addr2", imem_req_addr,  32'h8000_0000);
        lat = 1;
        step();
        step();
        check("rr_inst_pc",   inst_pc, 32'h8000_0000);
        check("rr_inst",      inst,    mem_data(32'h8000_0000));

        // PC wrap at the top of the address space.
        redirect_valid = 1'b1;
        redirect_pc    = 32'hFFFF_FFFC;
        step();
        redirect_valid = 1'b0;
        check("wr_req_addr", imem_req_addr, 32'hFFFF_FFFC);
        step();
        step();
        check("wr_inst_pc",  inst_pc, 32'hFFFF_FFFC);
        step();
        check("wr_wrap_addr", imem_req_addr, 32'h0000_0000);
        check("wr_wrap_pc",   pc,            32'h0000_0000);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
